// File: rtl/popcnt5_seq_accum.sv
// Sequential popcount: feeds a wide word one 5-bit slice per cycle to an external
// rd53 bit-count stage and accumulates its 3-bit results into a total count.
module popcnt5_seq_accum #(
  parameter int NSLICE = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [5*NSLICE-1:0]                in_data,
  output logic [4:0]                         pc_i,
  input  logic [2:0]                         pc_o,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(5*NSLICE+1)-1:0]      out_count
);

  localparam int W  = 5 * NSLICE;
  localparam int CW = $clog2(5 * NSLICE + 1);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [4:0]      slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Slice select written as a compare-mux so non-power-of-two NSLICE never indexes past the word.
  always_comb begin
    slice = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx_q == IW'(k)) slice = word_q[5*k +: 5];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d = acc_q + CW'(pc_o);
        if (idx_q == IW'(NSLICE - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_count = (state_q == DONE) ? acc_q : '0;
  assign pc_i      = (state_q == SCAN) ? slice : 5'b0;

endmodule

// File: tb/tb_popcnt5_seq_accum.sv
// Bench for popcnt5_seq_accum: NSLICE=4 and NSLICE=1 instances, each wrapped
// around a behavioural rd53 (ones count of the 5-bit slice).
module tb_popcnt5_seq_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [19:0] in_data;
  logic        in_ready, out_valid;
  logic [4:0]  pc_i;
  logic [2:0]  pc_o;
  logic [4:0]  out_count;

  logic        in_valid1, out_ready1;
  logic [4:0]  in_data1;
  logic        in_ready1, out_valid1;
  logic [4:0]  pc_i1;
  logic [2:0]  pc_o1;
  logic [2:0]  out_count1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always_comb pc_o  = 3'($countones(pc_i));
  always_comb pc_o1 = 3'($countones(pc_i1));

  popcnt5_seq_accum #(.NSLICE(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .pc_i(pc_i), .pc_o(pc_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count)
  );

  popcnt5_seq_accum #(.NSLICE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .pc_i(pc_i1), .pc_o(pc_o1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_count(out_count1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called one step after a rising edge with the block idle.
  task automatic run_word(input logic [19:0] d, input int exp, input int stall);
    int lat;
    logic [4:0] seq[$];
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    chk("accept_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 20'($urandom);
    seq.push_back(pc_i);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (!out_valid) seq.push_back(pc_i);
    end
    chk("latency", lat, 4);
    chk("num_slices", seq.size(), 4);
    for (int k = 0; k < seq.size() && k < 4; k++)
      chk($sformatf("pc_i_slice%0d", k), int'(seq[k]), int'((d >> (5*k)) & 20'h1F));
    chk("count", int'(out_count), exp);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_count", int'(out_count), exp);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_hs", int'(in_ready), 1);
    chk("valid_after_hs", int'(out_valid), 0);
  endtask

  typedef struct {
    logic [19:0] data;
    int          exp_count;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    logic [19:0] r;
    logic [4:0]  exp_seq [4];

    vecs[0] = '{20'hFFFFF, 20};
    vecs[1] = '{20'h00000, 0};
    vecs[2] = '{20'h08CEF, 10};
    vecs[3] = '{20'h00421, 3};
    vecs[4] = '{20'h12345, 7};
    vecs[5] = '{20'hAAAAA, 10};
    vecs[6] = '{20'h55555, 10};
    vecs[7] = '{20'h80001, 2};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    // Reset with random stimulus on the inputs
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 20'($urandom);
      out_ready = 1'($urandom);
      in_valid1 = 1'($urandom);
      in_data1  = 5'($urandom);
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_pc_i", int'(pc_i), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid1", int'(out_valid1), 0);
    end
    in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_pc_i", int'(pc_i), 0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) run_word(vecs[i].data, vecs[i].exp_count, i % 3);

    // Explicit slice order for 20'h08CEF
    exp_seq = '{5'b01111, 5'b00111, 5'b00011, 5'b00001};
    in_valid = 1'b1; in_data = 20'h08CEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("order_pc_i", int'(pc_i), int'(exp_seq[k]));
      @(posedge clk); #1;
    end
    chk("order_count", int'(out_count), 10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Downstream stall with a pending upstream word
    in_valid = 1'b1; in_data = 20'hFFFFF;
    @(posedge clk); #1;
    in_data = 20'h00421;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_count", int'(out_count), 20);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_count", int'(out_count), 20);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_pending_count", int'(out_count), 3);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset two cycles into SCAN
    in_valid = 1'b1; in_data = 20'hFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_pc_i", int'(pc_i), 0);
    chk("midrst_out_count", int'(out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_word(20'h00421, 3, 0);

    // Random words against the ones-count reference
    for (int i = 0; i < 30; i++) begin
      r = 20'($urandom);
      run_word(r, $countones(r), int'($urandom_range(0, 3)));
    end

    // Single-slice instance
    in_valid1 = 1'b1; in_data1 = 5'b10110;
    chk("n1_in_ready", int'(in_ready1), 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_pc_i", int'(pc_i1), 5'b10110);
    chk("n1_valid_early", int'(out_valid1), 0);
    @(posedge clk); #1;
    chk("n1_out_valid", int'(out_valid1), 1);
    chk("n1_count", int'(out_count1), 3);
    chk("n1_pc_i_done", int'(pc_i1), 0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("n1_ready_after", int'(in_ready1), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcnt5_seq_accum.md
# popcnt5_seq_accum

Sequential population-count accumulator wrapped around the combinational 5-input bit-count stage (`rd53`: inputs `i_0_`..`i_4_`; outputs `o_2_` weight 1, `o_1_` weight 2, `o_0_` weight 4). It accepts a wide word over a valid/ready handshake and feeds it one 5-bit slice per cycle to the bit-count stage. It sums the 3-bit results and presents the total count downstream over a second valid/ready handshake. The block sits directly upstream (driver) and downstream (consumer) of the bit-count stage.

## Interface
- `NSLICE`, default 4: number of 5-bit slices per word; legal range is NSLICE ≥ 1. Word width is `W = 5*NSLICE`.
- `CW`, derived (localparam): `clog2(5*NSLICE+1)`, which is 5 for the default.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: block can accept a word.
- `in_data` input W: word to count; slice k is `in_data[5k+4:5k]`.
- `pc_i` output 5: slice driven to the bit-count stage; `pc_i[j]` connects to `i_j_`.
- `pc_o` input 3: bit-count result; `pc_o[0]`=`o_2_`, `pc_o[1]`=`o_1_`, `pc_o[2]`=`o_0_`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_count` output CW: total number of ones in the accepted word.

## Operation
- The FSM has three states: IDLE, SCAN and DONE. Registered state comprises:
  - `word` (W bits)
  - `idx` (`clog2(NSLICE)` bits, minimum 1)
  - `acc` (CW bits)
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `in_data` into `word`, set `acc`=0 and `idx`=0, go to SCAN.
  - `in_data` is ignored while `in_valid` is low.
- SCAN:
  - `in_ready`=0.
  - `pc_i` = `word[5*idx+4:5*idx]` (combinational mux).
  - Each cycle: `acc <= acc + pc_o` (pc_o zero-extended to CW), then `idx <= idx+1`.
  - When `idx == NSLICE-1`, the final add is performed, `idx` is cleared and the FSM goes to DONE.
- DONE:
  - `out_valid`=1.
  - `out_count`=`acc`, held stable until the handshake completes.
  - On `out_ready`, go to IDLE.
- No overlap: a new word is never accepted while in SCAN or DONE.
- `pc_i` = 5'b0 outside SCAN.
- Width rule: maximum sum is 5*NSLICE < 2^CW, so `acc` never overflows. No saturation logic.
- `pc_o` > 5 cannot occur with a correct bit-count stage. The block does not check for it and adds the value as received.

## Timing
- Reset (`rst_n` low, asynchronous, at any time including mid-SCAN or in DONE):
  - state=IDLE, `acc`=0, `idx`=0, `word`=0.
  - `out_valid`=0, `out_count`=0, `pc_i`=0.
  - `in_ready` reads 1 during reset (IDLE), but no handshake is honoured while `rst_n` is low.
  - After release, operation restarts cleanly; a partially summed word is discarded.
- `out_valid`, `out_count` and `in_ready` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: word accepted at edge T → `out_valid` rises after edge T+NSLICE.
- Throughput: with `out_ready` tied high, one word per NSLICE+2 cycles (accept, NSLICE scan, 1 DONE).
- Result handshake completes at edge T' → `in_ready`=1 in the cycle following T'.
- Downstream stall: the block stays in DONE indefinitely with `out_count` unchanged. Upstream sees `in_ready`=0 for the whole stall.
- Critical path: `word` mux → bit-count stage → CW-bit adder → `acc`, all within one cycle.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `out_valid`=0, `out_count`=0, `pc_i`=0. After release → `in_ready`=1.
- Full and empty words (NSLICE=4): `in_data`=20'hFFFFF → `out_count`=20, `out_valid` rises 4 cycles after accept. `in_data`=20'h00000 → `out_count`=0.
- Slice ordering: `in_data`=20'h08CEF (slices 4,3,2,1 from LSB) →
  - `pc_i` sequence is 5'b01111, 5'b00111, 5'b00011, 5'b00001.
  - `out_count`=10.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE → `out_count` stable and `in_ready`=0.
  - A pending `in_valid` with new data is not accepted.
  - Raise `out_ready` → IDLE next cycle, the pending word is accepted, and its count is correct.
- Reset mid-operation: drop `rst_n` two cycles into SCAN on 20'hFFFFF → immediate IDLE with `acc`=0. The next word, 20'h00421, yields `out_count`=3.
- NSLICE=1: `in_data`=5'b10110 → single SCAN cycle, `out_count`=3.
